branch_control_unit: RTL



---
 rtl/cpu_control_pkg.sv | 26 ++
 rtl/flags_register.sv | 27 ++
 rtl/branch_control_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/cpu_control_pkg.sv
// cpu_control_pkg: shared opcode, ALU, condition-code and control-bundle definitions
package cpu_control_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_SUBI,
    OP_CMP, OP_MOVI, OP_LDR, OP_STR, OP_B, OP_BEQ, OP_BNE, OP_BLT
  } opcode_t;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b111;
  typedef enum logic [1:0] {COND_ALWAYS, COND_EQ, COND_NE, COND_LT} cond_t;
  typedef struct packed {
    logic pc_sel;
    logic obtain_pc;
    logic write_en;
    logic write_mem;
    logic result_sel;
    logic data2_sel;
    logic [2:0] alu;
    logic branch;
    cond_t cond;
    logic set_flags;
  } ctrl_t;
endpackage

// File: rtl/flags_register.sv
// flags_register: architectural NZVC register with set-enable and branch condition evaluator
module flags_register
  import cpu_control_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       set_en,
  input  logic [3:0] flags_in,
  input  cond_t      cond,
  output logic [3:0] flags_q,
  output logic       cond_pass
);
  logic [3:0] flags_d;
  // next flags: capture the ALU flags only when the instruction in Execute sets them
  always_comb begin
    flags_d = set_en ? flags_in : flags_q;
    cond_pass = cond == COND_ALWAYS ? 1'b1 :
                cond == COND_EQ     ? flags_q[2] :
                cond == COND_NE     ? !flags_q[2] :
                                      flags_q[3] ^ flags_q[1];
  end
  // flags state register
  always_ff @(posedge clock) begin
    if (reset) flags_q <= '0;
    else flags_q <= flags_d;
  end
endmodule

// File: rtl/branch_control_unit.sv
// branch_control_unit: decode-stage control, D->E branch state, flags and branch resolution
module branch_control_unit
  import cpu_control_pkg::*;
#(
  parameter int OPCODEWIDTH = 4,
  parameter int ALUCTRLWIDTH = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [OPCODEWIDTH-1:0]  opcodeD,
  input  logic                    flushE,
  input  logic                    N,
  input  logic                    Z,
  input  logic                    V,
  input  logic                    C,
  output logic                    PCSelectorFD,
  output logic                    obtainPCAsR1DD,
  output logic                    writeEnableDD,
  output logic                    writeDataEnableMD,
  output logic                    resultSelectorWBD,
  output logic                    data2SelectorED,
  output logic [ALUCTRLWIDTH-1:0] aluControlED,
  output logic                    takeBranchE,
  output logic [3:0]              flagsQ
);
  ctrl_t ctrl;
  logic branch_e_d, branch_e_q, set_flags_e_d, set_flags_e_q, cond_pass;
  cond_t cond_e_d, cond_e_q;
  // opcode decoder; all-zero NOP is the default so a flushed slot is a bubble
  always_comb begin
    ctrl = '0;
    case (opcode_t'(opcodeD))
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        ctrl.write_en = 1'b1;
        ctrl.set_flags = 1'b1;
        ctrl.alu = opcodeD[2:0] - 3'd1;
      end
      OP_ADDI, OP_SUBI: begin
        ctrl.write_en = 1'b1;
        ctrl.data2_sel = 1'b1;
        ctrl.set_flags = 1'b1;
        ctrl.alu = opcodeD[0] ? ALU_SUB : ALU_ADD;
      end
      OP_CMP: begin
        ctrl.alu = ALU_SUB;
        ctrl.set_flags = 1'b1;
      end
      OP_MOVI: begin
        ctrl.write_en = 1'b1;
        ctrl.data2_sel = 1'b1;
        ctrl.alu = ALU_PASSB;
      end
      OP_LDR: begin
        ctrl.write_en = 1'b1;
        ctrl.data2_sel = 1'b1;
        ctrl.result_sel = 1'b1;
      end
      OP_STR: begin
        ctrl.write_mem = 1'b1;
        ctrl.data2_sel = 1'b1;
      end
      OP_B, OP_BEQ, OP_BNE, OP_BLT: begin
        ctrl.pc_sel = 1'b1;
        ctrl.obtain_pc = 1'b1;
        ctrl.data2_sel = 1'b1;
        ctrl.branch = 1'b1;
        ctrl.cond = cond_t'(opcodeD[1:0]);
      end
      default: ;
    endcase
  end
  // D->E next state: a flush loads a bubble, mirroring the CPU pipeline register
  always_comb begin
    branch_e_d = flushE ? 1'b0 : ctrl.branch;
    cond_e_d = flushE ? COND_ALWAYS : ctrl.cond;
    set_flags_e_d = flushE ? 1'b0 : ctrl.set_flags;
  end
  // D->E state register, loaded every edge
  always_ff @(posedge clock) begin
    if (reset) begin
      branch_e_q <= 1'b0;
      cond_e_q <= COND_ALWAYS;
      set_flags_e_q <= 1'b0;
    end else begin
      branch_e_q <= branch_e_d;
      cond_e_q <= cond_e_d;
      set_flags_e_q <= set_flags_e_d;
    end
  end
  flags_register u_flags (
    .clock(clock),
    .reset(reset),
    .set_en(set_flags_e_q),
    .flags_in({N, Z, V, C}),
    .cond(cond_e_q),
    .flags_q(flagsQ),
    .cond_pass(cond_pass)
  );
  assign PCSelectorFD = ctrl.pc_sel;
  assign obtainPCAsR1DD = ctrl.obtain_pc;
  assign writeEnableDD = ctrl.write_en;
  assign writeDataEnableMD = ctrl.write_mem;
  assign resultSelectorWBD = ctrl.result_sel;
  assign data2SelectorED = ctrl.data2_sel;
  assign aluControlED = ctrl.alu;
  assign takeBranchE = branch_e_q & cond_pass;
endmodule
